// File: rtl/ccff_loader_pkg.sv
// ccff_loader_pkg: shared types and helpers for the configuration-chain loader.
//   - state_e      : loader FSM states (CHECK exists only with CCFF_LOADER_CRC_EN)
//   - CRC16_POLY   : CRC-16-CCITT polynomial
//   - CRC16_INIT   : CRC-16-CCITT seed
//   - crc16_step() : advance the CRC by one serial bit, MSB-first
package ccff_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
`ifdef CCFF_LOADER_CRC_EN
        ST_CHECK = 3'd2,
`endif
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } state_e;

    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    // One serial step of CRC-16-CCITT: feedback is the outgoing MSB xor the new bit.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
        logic fb;
        fb         = crc[15] ^ din;
        crc16_step = {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/ccff_loader_if.sv
// ccff_loader_if: bitstream word stream into the loader.
//   s_data  : NUM_CHAINS*BITS_PER_WORD bitstream word (DATA_W bits)
//   s_valid : source has a word
//   s_ready : loader accepts a word this cycle
// Modports: master = bitstream source, slave = ccff_loader.
interface ccff_loader_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/ccff_word_serializer.sv
// ccff_word_serializer: one-word holding register that slices a bitstream word
// onto the chain heads, NUM_CHAINS bits per shift, lowest slice first.
// Ports:
//   prog_clk, prog_reset_n : clock, async active-low reset
//   s_if (slave)           : word stream; s_ready is generated here
//   clr                    : drop any held word (start/abort)
//   capture_en             : loader is in LOAD this cycle; handshakes fill the register
//   feed_next              : next cycle is LOAD and more payload words are owed
//   trailer_next           : next cycle is CHECK; offer ready for the trailer word
//   take                   : handshake happening this cycle
//   ccff_head, shift_en    : registered chain data and advance strobe
module ccff_word_serializer
    import ccff_loader_pkg::*;
#(
    parameter int NUM_CHAINS    = 2,
    parameter int BITS_PER_WORD = 8
) (
    input  logic                  prog_clk,
    input  logic                  prog_reset_n,
    ccff_loader_if.slave          s_if,
    input  logic                  clr,
    input  logic                  capture_en,
    input  logic                  feed_next,
    input  logic                  trailer_next,
    output logic                  take,
    output logic [NUM_CHAINS-1:0] ccff_head,
    output logic                  shift_en
);

    localparam int DATA_W = NUM_CHAINS * BITS_PER_WORD;
    localparam int IDX_W  = (BITS_PER_WORD > 1) ? $clog2(BITS_PER_WORD) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BITS_PER_WORD - 1);

    logic [DATA_W-1:0]     word_q, word_d;
    logic                  full_q, full_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [NUM_CHAINS-1:0] head_q, head_d;
    logic                  shift_q, shift_d;
    logic                  ready_q, ready_d;

    assign take        = s_if.s_valid & ready_q;
    assign s_if.s_ready = ready_q;
    assign ccff_head   = head_q;
    assign shift_en    = shift_q;

    // Next holding-register contents, and the registered outputs derived from them.
    always_comb begin
        word_d = word_q;
        full_d = full_q;
        idx_d  = idx_q;
        if (clr) begin
            full_d = 1'b0;
            idx_d  = {IDX_W{1'b0}};
        end else if (full_q) begin
            if (idx_q == LAST_IDX) begin
                // Last slice going out: refill in the same edge so words run back-to-back.
                idx_d = {IDX_W{1'b0}};
                if (capture_en && take) begin
                    word_d = s_if.s_data;
                    full_d = 1'b1;
                end else begin
                    full_d = 1'b0;
                end
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end else if (capture_en && take) begin
            word_d = s_if.s_data;
            full_d = 1'b1;
            idx_d  = {IDX_W{1'b0}};
        end else begin
            full_d = 1'b0;
        end

        // Outputs are registered copies of what the next cycle presents; heads hold on stall.
        if (full_d) begin
            head_d = NUM_CHAINS'(word_d >> (int'(idx_d) * NUM_CHAINS));
        end else begin
            head_d = head_q;
        end
        shift_d = full_d;
        ready_d = (feed_next & (~full_d | (idx_d == LAST_IDX))) | trailer_next;
    end

    // Holding register, slice index and registered outputs.
    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            word_q  <= {DATA_W{1'b0}};
            full_q  <= 1'b0;
            idx_q   <= {IDX_W{1'b0}};
            head_q  <= {NUM_CHAINS{1'b0}};
            shift_q <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            word_q  <= word_d;
            full_q  <= full_d;
            idx_q   <= idx_d;
            head_q  <= head_d;
            shift_q <= shift_d;
            ready_q <= ready_d;
        end
    end

endmodule

// File: rtl/ccff_loader.sv
// ccff_loader: sequences a configuration-chain load. Bitstream words arrive on
// s_if and are serialised onto NUM_CHAINS chain heads, one bit per chain per
// shift, for CHAIN_LEN shifts. The fabric stays isolated until DONE.
// Optional feature macro: CCFF_LOADER_CRC_EN adds a CRC-16-CCITT over every
// shifted bit (chain 0 first) and a CHECK state that compares a trailer word.
// Ports:
//   prog_clk, prog_reset_n : configuration clock, async active-low reset
//   start, abort           : begin a load / return to IDLE (abort has priority)
//   s_if (slave)           : bitstream word stream
//   ccff_head, shift_en    : serial chain data and advance strobe
//   isol_n                 : isolation release (high only in DONE)
//   busy, done, err        : status
module ccff_loader
    import ccff_loader_pkg::*;
#(
    parameter int NUM_CHAINS    = 2,
    parameter int BITS_PER_WORD = 8,
    parameter int CHAIN_LEN     = 1024
) (
    input  logic                  prog_clk,
    input  logic                  prog_reset_n,
    input  logic                  start,
    input  logic                  abort,
    ccff_loader_if.slave          s_if,
    output logic [NUM_CHAINS-1:0] ccff_head,
    output logic                  shift_en,
    output logic                  isol_n,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int NUM_WORDS = (BITS_PER_WORD > 0) ? (CHAIN_LEN / BITS_PER_WORD) : 1;
    localparam int SC_W      = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
    localparam int WC_W      = (NUM_WORDS > 0) ? $clog2(NUM_WORDS + 1) : 1;
    localparam logic [SC_W-1:0] LAST_SHIFT  = SC_W'(CHAIN_LEN - 1);
    localparam logic [WC_W-1:0] NUM_WORDS_C = WC_W'(NUM_WORDS);

    if ((CHAIN_LEN <= 0) || (BITS_PER_WORD <= 0) || ((CHAIN_LEN % BITS_PER_WORD) != 0)) begin : g_bad_len
        $error("ccff_loader: CHAIN_LEN must be a nonzero multiple of BITS_PER_WORD");
    end

    state_e            state_q, state_d;
    logic [SC_W-1:0]   shift_cnt_q, shift_cnt_d;
    logic [WC_W-1:0]   word_cnt_q, word_cnt_d;
    logic              isol_n_q, isol_n_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              clr_s, take_s, feed_s, trailer_s, shift_en_s;
    logic [NUM_CHAINS-1:0] head_s;

`ifdef CCFF_LOADER_CRC_EN
    localparam int CMP_W = (NUM_CHAINS * BITS_PER_WORD < 16) ? (NUM_CHAINS * BITS_PER_WORD) : 16;
    logic [15:0] crc_q, crc_d;
`endif

    ccff_word_serializer #(
        .NUM_CHAINS   (NUM_CHAINS),
        .BITS_PER_WORD(BITS_PER_WORD)
    ) u_ser (
        .prog_clk    (prog_clk),
        .prog_reset_n(prog_reset_n),
        .s_if        (s_if),
        .clr         (clr_s),
        .capture_en  (state_q == ST_LOAD),
        .feed_next   (feed_s),
        .trailer_next(trailer_s),
        .take        (take_s),
        .ccff_head   (head_s),
        .shift_en    (shift_en_s)
    );

    assign ccff_head = head_s;
    assign shift_en  = shift_en_s;
    assign isol_n    = isol_n_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

    // FSM next state, shift/word counters, CRC accumulation and status outputs.
    always_comb begin
        state_d     = state_q;
        shift_cnt_d = shift_cnt_q;
        word_cnt_d  = word_cnt_q;
        clr_s       = 1'b0;
`ifdef CCFF_LOADER_CRC_EN
        crc_d       = crc_q;
`endif
        if (abort) begin
            state_d     = ST_IDLE;
            shift_cnt_d = {SC_W{1'b0}};
            word_cnt_d  = {WC_W{1'b0}};
            clr_s       = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start) begin
                        state_d     = ST_LOAD;
                        shift_cnt_d = {SC_W{1'b0}};
                        word_cnt_d  = {WC_W{1'b0}};
                        clr_s       = 1'b1;
`ifdef CCFF_LOADER_CRC_EN
                        crc_d       = CRC16_INIT;
`endif
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_LOAD: begin
                    if (take_s) begin
                        word_cnt_d = word_cnt_q + 1'b1;
                    end else begin
                        word_cnt_d = word_cnt_q;
                    end
                    if (shift_en_s) begin
`ifdef CCFF_LOADER_CRC_EN
                        for (int c = 0; c < NUM_CHAINS; c++) begin
                            crc_d = crc16_step(crc_d, head_s[c]);
                        end
`endif
                        if (shift_cnt_q == LAST_SHIFT) begin
                            shift_cnt_d = {SC_W{1'b0}};
`ifdef CCFF_LOADER_CRC_EN
                            state_d     = ST_CHECK;
`else
                            state_d     = ST_DONE;
`endif
                        end else begin
                            shift_cnt_d = shift_cnt_q + 1'b1;
                        end
                    end else begin
                        shift_cnt_d = shift_cnt_q;
                    end
                end
`ifdef CCFF_LOADER_CRC_EN
                ST_CHECK: begin
                    // Words narrower than 16 bits carry only the low CRC bits.
                    if (take_s) begin
                        if (s_if.s_data[CMP_W-1:0] == crc_q[CMP_W-1:0]) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_ERROR;
                        end
                    end else begin
                        state_d = ST_CHECK;
                    end
                end
`endif
                default: begin
                    state_d = ST_IDLE;
                    clr_s   = 1'b1;
                end
            endcase
        end

        // Ready is only offered while payload words are still owed, so it falls with the final word.
        feed_s    = (state_d == ST_LOAD) && (word_cnt_d < NUM_WORDS_C);
`ifdef CCFF_LOADER_CRC_EN
        trailer_s = (state_d == ST_CHECK);
        busy_d    = (state_d == ST_LOAD) || (state_d == ST_CHECK);
`else
        trailer_s = 1'b0;
        busy_d    = (state_d == ST_LOAD);
`endif
        isol_n_d  = (state_d == ST_DONE);
        done_d    = (state_d == ST_DONE);
        err_d     = (state_d == ST_ERROR);
    end

    // State, counters and registered status outputs.
    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            state_q     <= ST_IDLE;
            shift_cnt_q <= {SC_W{1'b0}};
            word_cnt_q  <= {WC_W{1'b0}};
            isol_n_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
`ifdef CCFF_LOADER_CRC_EN
            crc_q       <= CRC16_INIT;
`endif
        end else begin
            state_q     <= state_d;
            shift_cnt_q <= shift_cnt_d;
            word_cnt_q  <= word_cnt_d;
            isol_n_q    <= isol_n_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
`ifdef CCFF_LOADER_CRC_EN
            crc_q       <= crc_d;
`endif
        end
    end

endmodule

// File: tb/tb_ccff_loader.sv
// tb_ccff_loader: directed bench for ccff_loader with NUM_CHAINS=2,
// BITS_PER_WORD=4, CHAIN_LEN=8. Expected chain slices are queued when a word
// is offered and popped on every shift_en cycle. Honours CCFF_LOADER_CRC_EN.
module tb_ccff_loader;

    localparam int NC = 2;
    localparam int BPW = 4;
    localparam int CL = 8;
    localparam int DW = NC * BPW;

    logic          prog_clk     = 1'b0;
    logic          prog_reset_n = 1'b1;
    logic          start        = 1'b0;
    logic          abort        = 1'b0;
    logic [NC-1:0] ccff_head;
    logic          shift_en, isol_n, busy, done, err;

    ccff_loader_if #(.DATA_W(DW)) s_if ();

    ccff_loader #(
        .NUM_CHAINS   (NC),
        .BITS_PER_WORD(BPW),
        .CHAIN_LEN    (CL)
    ) dut (
        .prog_clk    (prog_clk),
        .prog_reset_n(prog_reset_n),
        .start       (start),
        .abort       (abort),
        .s_if        (s_if),
        .ccff_head   (ccff_head),
        .shift_en    (shift_en),
        .isol_n      (isol_n),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 prog_clk = ~prog_clk;

    int            n_cmp   = 0;
    int            n_fail  = 0;
    int            n_shift = 0;
    int            n_stall = 0;
    logic [NC-1:0] sb[$];
    logic [NC-1:0] last_head = '0;
    logic [15:0]   tb_crc    = 16'hFFFF;

    function automatic logic [15:0] crc_bit(input logic [15:0] c, input logic b);
        logic [15:0] r;
        r = {c[14:0], 1'b0};
        if (c[15] ^ b) r = r ^ 16'h1021;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and score the chain output of that cycle.
    task automatic tick();
        logic [NC-1:0] exp_head;
        @(negedge prog_clk);
        if (shift_en === 1'b1) begin
            exp_head = (sb.size() != 0) ? sb.pop_front() : 'x;
            chk("ccff_head", 32'(ccff_head), 32'(exp_head));
            n_shift++;
            last_head = ccff_head;
        end else if (busy === 1'b1 && n_shift > 0 && n_shift < CL) begin
            n_stall++;
            chk("stall_hold", 32'(ccff_head), 32'(last_head));
        end
    endtask

    task automatic new_load();
        n_shift = 0;
        n_stall = 0;
        tb_crc  = 16'hFFFF;
        sb.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_ready", 32'(s_if.s_ready), 32'd1);
        chk("start_isol", 32'(isol_n), 32'd0);
    endtask

    // Offer one word and hold it until the handshake edge has passed.
    task automatic send(input logic [DW-1:0] w, input bit push);
        bit            got;
        logic [NC-1:0] sl;
        got = 1'b0;
        s_if.s_data  = w;
        s_if.s_valid = 1'b1;
        if (push) begin
            for (int k = 0; k < BPW; k++) begin
                sl = w[k*NC +: NC];
                sb.push_back(sl);
                for (int c = 0; c < NC; c++) tb_crc = crc_bit(tb_crc, sl[c]);
            end
        end
        for (int i = 0; i < 50 && !got; i++) begin
            if (s_if.s_ready === 1'b1) got = 1'b1;
            tick();
        end
        chk("handshake", 32'(got), 32'd1);
    endtask

    // Drain remaining shifts, then check completion (and the trailer when CRC is built in).
    task automatic finish_load(input bit flip);
        logic [DW-1:0] trailer;
        for (int i = 0; i < 40 && n_shift < CL; i++) tick();
        chk("shift_total", 32'(n_shift), 32'(CL));
        tick();
`ifdef CCFF_LOADER_CRC_EN
        chk("check_busy", 32'(busy), 32'd1);
        chk("check_ready", 32'(s_if.s_ready), 32'd1);
        trailer = tb_crc[DW-1:0] ^ DW'(flip);
        send(trailer, 1'b0);
        s_if.s_valid = 1'b0;
        if (flip) begin
            chk("crc_err", 32'(err), 32'd1);
            chk("crc_err_isol", 32'(isol_n), 32'd0);
            chk("crc_err_done", 32'(done), 32'd0);
        end else begin
            chk("crc_done", 32'(done), 32'd1);
            chk("crc_done_isol", 32'(isol_n), 32'd1);
        end
`else
        trailer = DW'(flip);
        chk("done", 32'(done), 32'd1);
        chk("done_isol", 32'(isol_n), 32'd1);
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_trailer_unused", 32'(trailer), 32'(flip));
`endif
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_head"}, 32'(ccff_head), 32'd0);
        chk({tag, "_shift_en"}, 32'(shift_en), 32'd0);
        chk({tag, "_ready"}, 32'(s_if.s_ready), 32'd0);
        chk({tag, "_isol"}, 32'(isol_n), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        s_if.s_data  = '0;
        s_if.s_valid = 1'b0;
        #1 prog_reset_n = 1'b0;
        #2 chk_reset_outputs("reset");
        tick();
        tick();
        prog_reset_n = 1'b1;
        tick();
        chk("idle_ready", 32'(s_if.s_ready), 32'd0);

        // Basic gap-free load: B4 gives heads 00,01,11,10, then 00 x4.
        new_load();
        pulse_start();
        send(8'hB4, 1'b1);
        send(8'h00, 1'b1);
        s_if.s_valid = 1'b0;
        finish_load(1'b0);
        chk("basic_no_stall", 32'(n_stall), 32'd0);

        // Words offered in DONE are refused and DONE holds.
        s_if.s_data  = 8'h5A;
        s_if.s_valid = 1'b1;
        tick();
        chk("done_refuse", 32'(s_if.s_ready), 32'd0);
        tick();
        chk("done_hold", 32'(done), 32'd1);
        s_if.s_valid = 1'b0;

        // Three idle input cycles between words.
        new_load();
        pulse_start();
        send(8'h6C, 1'b1);
        s_if.s_valid = 1'b0;
        for (int i = 0; i < 20 && s_if.s_ready !== 1'b1; i++) tick();
        repeat (3) tick();
        send(8'h93, 1'b1);
        s_if.s_valid = 1'b0;
        finish_load(1'b0);
        chk("stall_cycles", 32'(n_stall), 32'd3);

        // Abort after shift 5, then reload from scratch.
        new_load();
        pulse_start();
        send(8'hB4, 1'b1);
        send(8'hE1, 1'b1);
        chk("abort_at_shift", 32'(n_shift), 32'd5);
        s_if.s_valid = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_shift_en", 32'(shift_en), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_isol", 32'(isol_n), 32'd0);
        chk("abort_ready", 32'(s_if.s_ready), 32'd0);
        new_load();
        pulse_start();
        send(8'h2D, 1'b1);
        send(8'hF0, 1'b1);
        s_if.s_valid = 1'b0;
        finish_load(1'b0);

        // Asynchronous reset mid-load.
        new_load();
        pulse_start();
        send(8'hB4, 1'b1);
        tick();
        #2 prog_reset_n = 1'b0;
        #1 chk_reset_outputs("midreset");
        s_if.s_valid = 1'b0;
        new_load();
        tick();
        prog_reset_n = 1'b1;
        repeat (3) tick();
        chk_reset_outputs("postreset");

`ifdef CCFF_LOADER_CRC_EN
        // Trailer with CRC bit 0 flipped must land in ERROR.
        new_load();
        pulse_start();
        send(8'hB4, 1'b1);
        send(8'h00, 1'b1);
        s_if.s_valid = 1'b0;
        finish_load(1'b1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ccff_loader.md
# ccff_loader

Configuration-chain loader that sequences bitstream programming of fabric tiles. Accepts bitstream words over a valid/ready stream and serialises them onto `NUM_CHAINS` parallel `ccff_head` chains, one bit per chain per shift. It gates chain advance with `shift_en` and holds the fabric isolated (`isol_n` low) until the load completes. It sits between the SoC-side bitstream source and the top-level `ccff_head`/`prog_clk` distribution of the tile array.

## Interface
Parameters:
- `NUM_CHAINS`, 2: parallel configuration chains driven simultaneously.
- `BITS_PER_WORD`, 8: shifts supplied by one input word.
- `CHAIN_LEN`, 1024: shifts per complete load. Must be a nonzero multiple of `BITS_PER_WORD`; elaboration error otherwise.

Ports:
- `prog_clk` in 1: configuration clock.
- `prog_reset_n` in 1: asynchronous active-low reset.
- `start` in 1: one-cycle pulse that begins a load; honoured in IDLE, DONE and ERROR.
- `abort` in 1: return to IDLE from any state.
- `s_data` in `NUM_CHAINS*BITS_PER_WORD`: bitstream word. Shift k uses bit `k*NUM_CHAINS+c` for chain c.
- `s_valid` in 1 / `s_ready` out 1: word handshake; a transfer occurs when both are high on a rising edge.
- `ccff_head` out `NUM_CHAINS`: serial data into the chains.
- `shift_en` out 1: the chains advance on the `prog_clk` edge at which `shift_en`=1.
- `isol_n` out 1: fabric isolation release.
- `busy`, `done`, `err` out 1: status.

## Operation
- States: IDLE, LOAD, CHECK (macro only), DONE, ERROR.
- IDLE:
  - `start` -> LOAD; shift counter and bit index cleared.
  - Without `start`, `s_ready`=0.
- LOAD:
  - One-word holding register with a bit index 0..`BITS_PER_WORD`-1.
  - `s_ready`=1 when the register is empty, or when it is full and on its last bit. This allows back-to-back words with no bubble.
  - Each cycle the register is full: present bit slice, `shift_en`=1, increment the shift counter.
  - Register empty: `shift_en`=0 (stall). `ccff_head` holds its last value.
  - After shift `CHAIN_LEN`-1: go to CHECK (macro on) or DONE. `s_ready` drops in the same cycle the final word is consumed.
- DONE: `done`=1, `isol_n`=1. Both remain until `start` or `abort`.
- ERROR: `err`=1, `isol_n`=0.
- `busy`=1 in LOAD and CHECK.
- `abort`:
  - Next state IDLE; holding register and counters cleared; `shift_en`=0; `isol_n`=0.
  - The partially shifted chain contents are undefined to software.
- `start` during LOAD or CHECK is ignored.
- `abort` and `start` in the same cycle: `abort` wins.
- Words offered in IDLE, DONE or ERROR are not accepted.

## Timing
- Reset values: `ccff_head`=0, `shift_en`=0, `s_ready`=0, `isol_n`=0, `busy`=0, `done`=0, `err`=0, state IDLE.
- All outputs are registered.
- `start` at edge N puts the block in LOAD from cycle N+1, with `s_ready`=1 in cycle N+1.
- A word accepted at edge M has its first slice on `ccff_head`, with `shift_en`=1, in cycle M+1. Data latency is one cycle.
- Gap-free input gives a full load of `CHAIN_LEN` consecutive `shift_en` cycles.
- `done` rises the cycle after the last `shift_en` cycle (macro off).
- Reset asserted mid-load returns every output to its reset value immediately.

## Configuration
- `CCFF_LOADER_CRC_EN` defined:
  - A CRC-16-CCITT (poly 0x1021, init 0xFFFF) accumulates every shifted bit, chain 0 first within a shift.
  - In CHECK, `s_ready`=1 for exactly one trailer word. Its low 16 bits are compared with the CRC.
  - Match -> DONE; mismatch -> ERROR. Either transition happens on the cycle after the trailer handshake.
  - CHECK waits indefinitely for the trailer.
- Macro undefined: no CRC logic and no CHECK state; LOAD -> DONE directly.

## Structure
- Package `ccff_loader_pkg` holds:
  - the state enum;
  - the CRC polynomial and init constants;
  - the `crc16_step` function.
- One sub-module, `ccff_word_serializer`, holds the word register, bit index, `s_ready` and slice generation. The FSM, counters and CRC remain in `ccff_loader`.

## Test plan
All tests use `NUM_CHAINS`=2, `BITS_PER_WORD`=4, `CHAIN_LEN`=8 unless noted.
- Basic load:
  - Stimulus: `start`, then words 0xB4 and 0x00 offered gap-free.
  - Required: `ccff_head` = 2'b00, 01, 11, 10, 00, 00, 00, 00 over 8 consecutive `shift_en` cycles; `done`=1 and `isol_n`=1 one cycle after the 8th shift.
- Input stall:
  - Stimulus: `s_valid` deasserted for 3 cycles between the two words.
  - Required: exactly 3 `shift_en`=0 cycles with `ccff_head` held; 8 shifts total; `done` asserted.
- Abort mid-load:
  - Stimulus: `abort` after shift 5.
  - Required: next cycle IDLE, `shift_en`=0, `busy`=0, `isol_n`=0. A following `start` reloads all 8 shifts correctly.
- Reset mid-load:
  - Stimulus: `prog_reset_n` pulsed low between clock edges.
  - Required: all outputs go to their reset values asynchronously, and remain there until `start`.
- CRC match (`CCFF_LOADER_CRC_EN`):
  - Stimulus: the basic load followed by a trailer carrying the correct CRC.
  - Required: DONE.
- CRC mismatch (`CCFF_LOADER_CRC_EN`):
  - Stimulus: the same load with CRC bit 0 flipped in the trailer.
  - Required: `err`=1 and `isol_n`=0.
